v7_peak_detector: RTL and testbench

//  Downstream consumer of the v7 shaping filter. Watches the 16-bit shaped stream for pulses above a
//  run-time threshold, finds each pulse's maximum and timestamps it. Delivers one (amplitude, time)

---
 rtl/v7_peak_detector.sv | 163 ++++++++++++++++
 tb/tb_v7_peak_detector.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/v7_peak_detector.sv
// Pulse peak finder on the shaped v7 stream: tracks each above-threshold pulse's maximum and timestamp,
// publishes one event per pulse into a 1-deep valid/ready slot. Optional macro: V7_PEAK_PILEUP_EN.
module v7_peak_detector #(
   parameter int unsigned SIZE_FILTER_DATA = 16,
   parameter int unsigned SIZE_TIME        = 32,
   parameter int unsigned HOLDOFF_CYCLES   = 8,
   parameter int unsigned MAX_WIDTH        = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   input  logic [SIZE_FILTER_DATA-1:0] threshold,
   output logic [SIZE_FILTER_DATA-1:0] peak_amp,
   output logic [SIZE_TIME-1:0]        peak_time,
   output logic                        peak_valid,
   input  logic                        peak_ready,
   output logic [15:0]                 lost_count
`ifdef V7_PEAK_PILEUP_EN
   ,
   output logic                        peak_pileup
`endif
);

   localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
   localparam int unsigned LOST_W = 16;

   if (HOLDOFF_CYCLES == 0 || MAX_WIDTH < 2) begin : g_param_check
      $error("v7_peak_detector: HOLDOFF_CYCLES must be >= 1 and MAX_WIDTH >= 2");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_HOLDOFF = 2'd2
   } state_e;

   state_e                      state_q;
   logic [SIZE_TIME-1:0]        ts_q;
   logic [SIZE_FILTER_DATA-1:0] max_q;
   logic [SIZE_TIME-1:0]        max_t_q;
   logic [HOLD_W-1:0]           hold_q;
   logic [SIZE_FILTER_DATA-1:0] amp_q;
   logic [SIZE_TIME-1:0]        time_q;
   logic                        valid_q;
   logic [LOST_W-1:0]           lost_q;

   logic                        above_c;
   logic                        gt_max_c;
   logic                        end_pub_c;
   logic                        pub_c;
   logic                        slot_free_c;
   logic [SIZE_FILTER_DATA-1:0] pub_amp_c;
   logic [SIZE_TIME-1:0]        pub_time_c;

`ifdef V7_PEAK_PILEUP_EN
   localparam int unsigned CNT_W = $clog2(MAX_WIDTH + 1);
   logic [CNT_W-1:0] width_q;
   logic             pileup_q;
   logic             force_pub_c;
`endif

   // Signed compares and the publish request for this edge.
   always_comb begin
      above_c     = $signed(filter_data) > $signed(threshold);
      gt_max_c    = $signed(filter_data) > $signed(max_q);
      end_pub_c   = (state_q == S_ARMED) && !above_c;
      pub_c       = end_pub_c;
      pub_amp_c   = max_q;
      pub_time_c  = max_t_q;
      slot_free_c = !valid_q || peak_ready;
`ifdef V7_PEAK_PILEUP_EN
      // The MAX_WIDTH-th armed sample is still above threshold, so it competes for the max.
      force_pub_c = (state_q == S_ARMED) && above_c && (width_q == CNT_W'(MAX_WIDTH - 1));
      pub_c       = end_pub_c || force_pub_c;
      if (force_pub_c && gt_max_c) begin
         pub_amp_c  = filter_data;
         pub_time_c = ts_q;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ts_q    <= '0;
         max_q   <= '0;
         max_t_q <= '0;
         hold_q  <= '0;
         amp_q   <= '0;
         time_q  <= '0;
         valid_q <= 1'b0;
         lost_q  <= '0;
      end else begin
         ts_q <= ts_q + SIZE_TIME'(1);

         case (state_q)
            S_IDLE: begin
               if (above_c) begin
                  state_q <= S_ARMED;
                  max_q   <= filter_data;
                  max_t_q <= ts_q;
               end
            end
            S_ARMED: begin
               if (pub_c) begin
                  state_q <= S_HOLDOFF;
                  hold_q  <= HOLD_W'(HOLDOFF_CYCLES);
               end else if (gt_max_c) begin
                  max_q   <= filter_data;
                  max_t_q <= ts_q;
               end
            end
            S_HOLDOFF: begin
               hold_q <= hold_q - HOLD_W'(1);
               if (hold_q == HOLD_W'(1)) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // 1-deep slot: a publish into a full, unaccepted slot is counted as lost.
         if (pub_c) begin
            if (slot_free_c) begin
               amp_q   <= pub_amp_c;
               time_q  <= pub_time_c;
               valid_q <= 1'b1;
            end else if (lost_q != '1) begin
               lost_q <= lost_q + LOST_W'(1);
            end
         end else if (peak_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef V7_PEAK_PILEUP_EN
   // Armed-sample counter (arming sample counts as 1) and the pileup flag carried with the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         width_q  <= '0;
         pileup_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && above_c) begin
            width_q <= CNT_W'(1);
         end else if (state_q == S_ARMED && !pub_c) begin
            width_q <= width_q + CNT_W'(1);
         end
         if (pub_c && slot_free_c) begin
            pileup_q <= force_pub_c;
         end
      end
   end

   assign peak_pileup = pileup_q;
`endif

   assign peak_amp   = amp_q;
   assign peak_time  = time_q;
   assign peak_valid = valid_q;
   assign lost_count = lost_q;

endmodule

// File: tb/tb_v7_peak_detector.sv
// Directed bench for v7_peak_detector: a vector table for the basic pulse plus hand-written
// sequences for holdoff, slot-full, plateau, signed, reset and (with V7_PEAK_PILEUP_EN) pileup cases.
module tb_v7_peak_detector;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] filter_data;
   logic [15:0] threshold;
   logic [15:0] peak_amp;
   logic [31:0] peak_time;
   logic        peak_valid;
   logic        peak_ready;
   logic [15:0] lost_count;
`ifdef V7_PEAK_PILEUP_EN
   logic        peak_pileup;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nev   = 0;

   typedef struct {
      logic [15:0] fd;
      logic        rdy;
      logic        ev;
      logic [15:0] amp;
      logic [31:0] t;
      logic [15:0] lost;
   } vec_t;

   vec_t tv[8];

   v7_peak_detector #(
      .SIZE_FILTER_DATA(16),
      .SIZE_TIME       (32),
      .HOLDOFF_CYCLES  (8),
      .MAX_WIDTH       (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .filter_data(filter_data),
      .threshold  (threshold),
      .peak_amp   (peak_amp),
      .peak_time  (peak_time),
      .peak_valid (peak_valid),
      .peak_ready (peak_ready),
      .lost_count (lost_count)
`ifdef V7_PEAK_PILEUP_EN
      ,
      .peak_pileup(peak_pileup)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [15:0] amp,
                          input logic [31:0] t, input logic [15:0] lost);
      chk({name, ".valid"}, 32'(peak_valid), 32'(v));
      chk({name, ".amp"},   32'(peak_amp),   32'(amp));
      chk({name, ".time"},  peak_time,       t);
      chk({name, ".lost"},  32'(lost_count), 32'(lost));
   endtask

   // One sample per cycle; outputs are looked at 1 time unit after the edge.
   task automatic step(input logic [15:0] fd, input logic rdy);
      filter_data = fd;
      peak_ready  = rdy;
      @(posedge clk);
      #1;
      cyc++;
      if (peak_valid) nev++;
   endtask

   task automatic feed(input logic [15:0] fd, input logic rdy, input int n);
      for (int i = 0; i < n; i++) step(fd, rdy);
   endtask

   // 50 is below threshold 100, so the pulse arms on its second sample.
   task automatic pulse(input logic rdy);
      step(16'd50, rdy);
      step(16'd150, rdy);
      step(16'd300, rdy);
      step(16'd250, rdy);
      step(16'd90, rdy);
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      filter_data = '0;
      threshold   = 16'd100;
      peak_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 16'd0, 32'd0, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      nev   = 0;
   endtask

   initial begin
      tv[0] = '{16'd0,   1'b1, 1'b0, 16'd0,   32'd0, 16'd0};
      tv[1] = '{16'd50,  1'b1, 1'b0, 16'd0,   32'd0, 16'd0};
      tv[2] = '{16'd150, 1'b1, 1'b0, 16'd0,   32'd0, 16'd0};
      tv[3] = '{16'd300, 1'b1, 1'b0, 16'd0,   32'd0, 16'd0};
      tv[4] = '{16'd250, 1'b1, 1'b0, 16'd0,   32'd0, 16'd0};
      tv[5] = '{16'd90,  1'b1, 1'b1, 16'd300, 32'd3, 16'd0};
      tv[6] = '{16'd0,   1'b1, 1'b0, 16'd300, 32'd3, 16'd0};
      tv[7] = '{16'd0,   1'b1, 1'b0, 16'd300, 32'd3, 16'd0};

      // Basic pulse: event published on the edge that samples 90, one cycle wide.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(tv[i].fd, tv[i].rdy);
         chk_out($sformatf("t1.v%0d", i), tv[i].ev, tv[i].amp, tv[i].t, tv[i].lost);
      end

      // Second pulse 4 samples after the first ends falls inside holdoff.
      do_reset();
      pulse(1'b1);
      feed(16'd0, 1'b1, 4);
      pulse(1'b1);
      feed(16'd0, 1'b1, 4);
      chk("t2a.events", 32'(nev), 32'd1);
      chk_out("t2a.end", 1'b0, 16'd300, 32'd2, 16'd0);

      // 9-sample gap: second pulse published, arming at tag 15, max at 16.
      do_reset();
      pulse(1'b1);
      feed(16'd0, 1'b1, 9);
      pulse(1'b1);
      chk_out("t2b.ev2", 1'b1, 16'd300, 32'd16, 16'd0);
      chk("t2b.events", 32'(nev), 32'd2);

      // Holdoff edge: sample at tag 12 is the last ignored one, tag 13 re-arms.
      do_reset();
      pulse(1'b1);
      feed(16'd0, 1'b1, 7);
      step(16'd150, 1'b1);
      step(16'd150, 1'b1);
      step(16'd90, 1'b1);
      chk_out("t2c.rearm", 1'b1, 16'd150, 32'd13, 16'd0);

      // Slot full: second event lost, first held until accepted.
      do_reset();
      step(16'd0, 1'b0);
      step(16'd150, 1'b0);
      step(16'd300, 1'b0);
      step(16'd90, 1'b0);
      chk_out("t3.ev1", 1'b1, 16'd300, 32'd2, 16'd0);
      feed(16'd0, 1'b0, 9);
      step(16'd150, 1'b0);
      step(16'd400, 1'b0);
      step(16'd90, 1'b0);
      chk_out("t3.full", 1'b1, 16'd300, 32'd2, 16'd1);
      step(16'd0, 1'b1);
      chk_out("t3.accept", 1'b0, 16'd300, 32'd2, 16'd1);
      step(16'd0, 1'b1);
      chk_out("t3.idle", 1'b0, 16'd300, 32'd2, 16'd1);

      // Plateau keeps the earliest tag.
      do_reset();
      step(16'd0, 1'b1);
      step(16'd200, 1'b1);
      step(16'd200, 1'b1);
      step(16'd200, 1'b1);
      step(16'd50, 1'b1);
      chk_out("t4.plateau", 1'b1, 16'd200, 32'd1, 16'd0);

      // Negative threshold: signed compare, sample equal to threshold ends the pulse.
      do_reset();
      threshold = 16'hFFCE;
      step(16'hFF9C, 1'b1);
      step(16'd10, 1'b1);
      step(16'hFFF6, 1'b1);
      chk("t4b.armed_no_ev", 32'(peak_valid), 32'd0);
      step(16'hFFCE, 1'b1);
      chk_out("t4b.signed", 1'b1, 16'd10, 32'd1, 16'd0);

      // Reset while armed with a pending event: everything discarded.
      do_reset();
      step(16'd150, 1'b0);
      step(16'd300, 1'b0);
      step(16'd90, 1'b0);
      feed(16'd0, 1'b0, 9);
      step(16'd200, 1'b0);
      step(16'd500, 1'b0);
      step(16'd300, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_out("t5.in_reset", 1'b0, 16'd0, 32'd0, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      nev   = 0;
      for (int i = 0; i < 5; i++) begin
         step(16'd100, 1'b0);
         step(16'd50, 1'b0);
         step(16'hFF38, 1'b0);
         step(16'd0, 1'b0);
      end
      chk("t5.events", 32'(nev), 32'd0);
      chk_out("t5.after", 1'b0, 16'd0, 32'd0, 16'd0);

`ifdef V7_PEAK_PILEUP_EN
      // Constant 1000: forced publish on the 64th armed sample, then a normal end after re-arming at 72.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step(16'd1000, 1'b1);
         if (i == 62) chk("t6.pre", 32'(peak_valid), 32'd0);
         if (i == 63) begin
            chk_out("t6.force", 1'b1, 16'd1000, 32'd0, 16'd0);
            chk("t6.pileup", 32'(peak_pileup), 32'd1);
         end
      end
      step(16'd0, 1'b1);
      chk_out("t6.normal", 1'b1, 16'd1000, 32'd72, 16'd0);
      chk("t6.pileup0", 32'(peak_pileup), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
